// File: rtl/simple_alu_pipe.sv
// Two-stage valid/ready integer ALU: S1 registers the operation, S2 registers result/flags/tag.
// Optional macro SIMPLE_ALU_OVF_TRAP_EN turns flags bit1 of ADD/ADDI/SUB into signed overflow.

`ifndef SIZE_OPCODE_I
`define SIZE_OPCODE_I   6
`define EXECUTION_FLAGS 6
`define OPC_NOP   6'd0
`define OPC_ADD   6'd1
`define OPC_ADDU  6'd2
`define OPC_SUB   6'd3
`define OPC_SUBU  6'd4
`define OPC_AND   6'd5
`define OPC_OR    6'd6
`define OPC_XOR   6'd7
`define OPC_NOR   6'd8
`define OPC_SLT   6'd9
`define OPC_SLTU  6'd10
`define OPC_ADDI  6'd11
`define OPC_ADDIU 6'd12
`define OPC_SLTI  6'd13
`define OPC_SLTIU 6'd14
`define OPC_ANDI  6'd15
`define OPC_ORI   6'd16
`define OPC_XORI  6'd17
`define OPC_LUI   6'd18
`define OPC_SLL   6'd19
`define OPC_SRL   6'd20
`define OPC_SRA   6'd21
`define OPC_SLLV  6'd22
`define OPC_SRLV  6'd23
`define OPC_SRAV  6'd24
`define OPC_MFHI  6'd25
`define OPC_MTHI  6'd26
`define OPC_MFLO  6'd27
`define OPC_MTLO  6'd28
`endif

module simple_alu_pipe #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int TAG_W  = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [`SIZE_OPCODE_I-1:0]   opcode_i,
    input  logic [DATA_W-1:0]           data1_i,
    input  logic [DATA_W-1:0]           data2_i,
    input  logic [IMM_W-1:0]            immd_i,
    input  logic [TAG_W-1:0]            tag_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [DATA_W-1:0]           result_o,
    output logic [`EXECUTION_FLAGS-1:0] flags_o,
    output logic [TAG_W-1:0]            tag_o
);

    // Handshake: a transfer happens on any cycle where valid and ready are both high;
    // a producer holds valid and its payload stable until that transfer.
    localparam int SH_W = $clog2(DATA_W);

    logic                        s1_valid_q, s1_valid_d;
    logic [`SIZE_OPCODE_I-1:0]   s1_op_q, s1_op_d;
    logic [DATA_W-1:0]           s1_d1_q, s1_d1_d;
    logic [DATA_W-1:0]           s1_d2_q, s1_d2_d;
    logic [IMM_W-1:0]            s1_imm_q, s1_imm_d;
    logic [TAG_W-1:0]            s1_tag_q, s1_tag_d;
    logic                        s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0]           s2_result_q, s2_result_d;
    logic [`EXECUTION_FLAGS-1:0] s2_flags_q, s2_flags_d;
    logic [TAG_W-1:0]            s2_tag_q, s2_tag_d;

    logic [DATA_W-1:0]           imm_sext, imm_zext;
    logic [DATA_W:0]             add_x, addi_x, sub_x;
    logic [SH_W-1:0]             sh_imm, sh_var;
    logic                        exc_add, exc_addi, exc_sub;
    logic                        wr_en, exec, exc;
    logic [DATA_W-1:0]           alu_result;
    logic [`EXECUTION_FLAGS-1:0] alu_flags;
    logic                        in_fire, s1_adv;

    always_comb begin
        imm_sext = {{(DATA_W-IMM_W){s1_imm_q[IMM_W-1]}}, s1_imm_q};
        imm_zext = {{(DATA_W-IMM_W){1'b0}}, s1_imm_q};
        add_x    = {1'b0, s1_d1_q} + {1'b0, s1_d2_q};
        addi_x   = {1'b0, s1_d1_q} + {1'b0, imm_sext};
        sub_x    = {1'b0, s1_d1_q} - {1'b0, s1_d2_q};
        sh_imm   = s1_imm_q[SH_W-1:0];
        sh_var   = s1_d1_q[SH_W-1:0];
`ifdef SIMPLE_ALU_OVF_TRAP_EN
        exc_add  = (s1_d1_q[DATA_W-1] == s1_d2_q[DATA_W-1]) &&
                   (add_x[DATA_W-1] != s1_d1_q[DATA_W-1]);
        exc_addi = (s1_d1_q[DATA_W-1] == imm_sext[DATA_W-1]) &&
                   (addi_x[DATA_W-1] != s1_d1_q[DATA_W-1]);
        exc_sub  = (s1_d1_q[DATA_W-1] != s1_d2_q[DATA_W-1]) &&
                   (sub_x[DATA_W-1] != s1_d1_q[DATA_W-1]);
`else
        exc_add  = add_x[DATA_W];
        exc_addi = addi_x[DATA_W];
        exc_sub  = sub_x[DATA_W];
`endif
    end

    // Immediate shifts act on data1; the V forms shift data2 by data1.
    always_comb begin
        alu_result = '0;
        wr_en      = 1'b1;
        exec       = 1'b1;
        exc        = 1'b0;
        case (s1_op_q)
            `OPC_ADD:   begin alu_result = add_x[DATA_W-1:0];  exc = exc_add;  end
            `OPC_ADDU:  alu_result = add_x[DATA_W-1:0];
            `OPC_SUB:   begin alu_result = sub_x[DATA_W-1:0];  exc = exc_sub;  end
            `OPC_SUBU:  alu_result = sub_x[DATA_W-1:0];
            `OPC_AND:   alu_result = s1_d1_q & s1_d2_q;
            `OPC_OR:    alu_result = s1_d1_q | s1_d2_q;
            `OPC_XOR:   alu_result = s1_d1_q ^ s1_d2_q;
            `OPC_NOR:   alu_result = ~(s1_d1_q | s1_d2_q);
            `OPC_SLT:   alu_result = {{(DATA_W-1){1'b0}}, $signed(s1_d1_q) < $signed(s1_d2_q)};
            `OPC_SLTU:  alu_result = {{(DATA_W-1){1'b0}}, s1_d1_q < s1_d2_q};
            `OPC_ADDI:  begin alu_result = addi_x[DATA_W-1:0]; exc = exc_addi; end
            `OPC_ADDIU: alu_result = addi_x[DATA_W-1:0];
            `OPC_SLTI:  alu_result = {{(DATA_W-1){1'b0}}, $signed(s1_d1_q) < $signed(imm_sext)};
            `OPC_SLTIU: alu_result = {{(DATA_W-1){1'b0}}, s1_d1_q < imm_zext};
            `OPC_ANDI:  alu_result = s1_d1_q & imm_zext;
            `OPC_ORI:   alu_result = s1_d1_q | imm_zext;
            `OPC_XORI:  alu_result = s1_d1_q ^ imm_zext;
            `OPC_LUI:   alu_result = {s1_imm_q, {(DATA_W-IMM_W){1'b0}}};
            `OPC_SLL:   alu_result = s1_d1_q << sh_imm;
            `OPC_SRL:   alu_result = s1_d1_q >> sh_imm;
            `OPC_SRA:   alu_result = $unsigned($signed(s1_d1_q) >>> sh_imm);
            `OPC_SLLV:  alu_result = s1_d2_q << sh_var;
            `OPC_SRLV:  alu_result = s1_d2_q >> sh_var;
            `OPC_SRAV:  alu_result = $unsigned($signed(s1_d2_q) >>> sh_var);
            `OPC_MFHI, `OPC_MTHI, `OPC_MFLO, `OPC_MTLO: alu_result = s1_d1_q;
            `OPC_NOP:   wr_en = 1'b0;
            default: begin
                wr_en = 1'b0;
                exec  = 1'b0;
            end
        endcase
        alu_flags    = '0;
        alu_flags[4] = wr_en;
        alu_flags[2] = exec;
        alu_flags[1] = exc;
    end

    always_comb begin
        in_ready_o  = !s1_valid_q || !s2_valid_q || out_ready_i;
        in_fire     = in_valid_i && in_ready_o;
        s1_adv      = s1_valid_q && (!s2_valid_q || out_ready_i);
        s1_valid_d  = s1_valid_q;
        s1_op_d     = s1_op_q;
        s1_d1_d     = s1_d1_q;
        s1_d2_d     = s1_d2_q;
        s1_imm_d    = s1_imm_q;
        s1_tag_d    = s1_tag_q;
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_flags_d  = s2_flags_q;
        s2_tag_d    = s2_tag_q;
        if (flush_i) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (in_fire) begin
                s1_valid_d = 1'b1;
                s1_op_d    = opcode_i;
                s1_d1_d    = data1_i;
                s1_d2_d    = data2_i;
                s1_imm_d   = immd_i;
                s1_tag_d   = tag_i;
            end else if (s1_adv) begin
                s1_valid_d = 1'b0;
            end
            // S2 only reloads when empty or draining, which keeps a stalled result stable.
            if (s1_adv) begin
                s2_valid_d  = 1'b1;
                s2_result_d = alu_result;
                s2_flags_d  = alu_flags;
                s2_tag_d    = s1_tag_q;
            end else if (out_ready_i) begin
                s2_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= '0;
            s1_d1_q     <= '0;
            s1_d2_q     <= '0;
            s1_imm_q    <= '0;
            s1_tag_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_flags_q  <= '0;
            s2_tag_q    <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_d1_q     <= s1_d1_d;
            s1_d2_q     <= s1_d2_d;
            s1_imm_q    <= s1_imm_d;
            s1_tag_q    <= s1_tag_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_flags_q  <= s2_flags_d;
            s2_tag_q    <= s2_tag_d;
        end
    end

    always_comb begin
        out_valid_o = s2_valid_q;
        result_o    = s2_result_q;
        flags_o     = s2_flags_q;
        tag_o       = s2_tag_q;
    end

endmodule

// File: tb/tb_simple_alu_pipe.sv
// Bench for simple_alu_pipe: directed vectors, an arithmetic reference model and a per-cycle scoreboard.
// Expectations follow SIMPLE_ALU_OVF_TRAP_EN the same way the design does.

`ifndef SIZE_OPCODE_I
`define SIZE_OPCODE_I   6
`define EXECUTION_FLAGS 6
`define OPC_NOP   6'd0
`define OPC_ADD   6'd1
`define OPC_ADDU  6'd2
`define OPC_SUB   6'd3
`define OPC_SUBU  6'd4
`define OPC_AND   6'd5
`define OPC_OR    6'd6
`define OPC_XOR   6'd7
`define OPC_NOR   6'd8
`define OPC_SLT   6'd9
`define OPC_SLTU  6'd10
`define OPC_ADDI  6'd11
`define OPC_ADDIU 6'd12
`define OPC_SLTI  6'd13
`define OPC_SLTIU 6'd14
`define OPC_ANDI  6'd15
`define OPC_ORI   6'd16
`define OPC_XORI  6'd17
`define OPC_LUI   6'd18
`define OPC_SLL   6'd19
`define OPC_SRL   6'd20
`define OPC_SRA   6'd21
`define OPC_SLLV  6'd22
`define OPC_SRLV  6'd23
`define OPC_SRAV  6'd24
`define OPC_MFHI  6'd25
`define OPC_MTHI  6'd26
`define OPC_MFLO  6'd27
`define OPC_MTLO  6'd28
`endif

module tb_simple_alu_pipe;

    localparam int W  = 32 + 6 + 8;
    localparam int NV = 32;
`ifdef SIMPLE_ALU_OVF_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk, rst, flush_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
    logic [5:0]  opcode_i, flags_o;
    logic [31:0] data1_i, data2_i, result_o;
    logic [15:0] immd_i;
    logic [7:0]  tag_i, tag_o;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    logic [W-1:0] exp_q[$];
    int           due_q[$];

    logic [5:0]  t_op  [NV];
    logic [31:0] t_d1  [NV];
    logic [31:0] t_d2  [NV];
    logic [15:0] t_imm [NV];

    simple_alu_pipe dut (
        .clk(clk), .reset(rst), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .opcode_i(opcode_i), .data1_i(data1_i), .data2_i(data2_i),
        .immd_i(immd_i), .tag_i(tag_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .result_o(result_o), .flags_o(flags_o), .tag_o(tag_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: result and flags from plain 64-bit arithmetic.
    function automatic logic [37:0] model(input logic [5:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [15:0] imm);
        longint sa, sb, si, ua, ub, uzi, usi, s;
        logic [31:0] r;
        logic wr, ex, ec;
        int sh;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        si  = longint'($signed(imm));
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        uzi = longint'({48'b0, imm});
        usi = si & 64'hFFFF_FFFF;
        wr = 1'b1; ex = 1'b1; ec = 1'b0; r = '0; s = 0;
        case (op)
            `OPC_ADD: begin
                s = sa + sb; r = s[31:0];
                ec = TRAP ? (s > 64'sd2147483647 || s < -64'sd2147483648) : (ua + ub > 64'hFFFF_FFFF);
            end
            `OPC_ADDU: begin s = ua + ub; r = s[31:0]; end
            `OPC_SUB: begin
                s = sa - sb; r = s[31:0];
                ec = TRAP ? (s > 64'sd2147483647 || s < -64'sd2147483648) : (ua < ub);
            end
            `OPC_SUBU: begin s = ua - ub; r = s[31:0]; end
            `OPC_AND:  r = a & b;
            `OPC_OR:   r = a | b;
            `OPC_XOR:  r = a ^ b;
            `OPC_NOR:  r = ~(a | b);
            `OPC_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
            `OPC_SLTU: r = (ua < ub) ? 32'd1 : 32'd0;
            `OPC_ADDI: begin
                s = sa + si; r = s[31:0];
                ec = TRAP ? (s > 64'sd2147483647 || s < -64'sd2147483648) : (ua + usi > 64'hFFFF_FFFF);
            end
            `OPC_ADDIU: begin s = sa + si; r = s[31:0]; end
            `OPC_SLTI:  r = (sa < si) ? 32'd1 : 32'd0;
            `OPC_SLTIU: r = (ua < uzi) ? 32'd1 : 32'd0;
            `OPC_ANDI:  begin s = ua & uzi; r = s[31:0]; end
            `OPC_ORI:   begin s = ua | uzi; r = s[31:0]; end
            `OPC_XORI:  begin s = ua ^ uzi; r = s[31:0]; end
            `OPC_LUI:   begin s = uzi * 65536; r = s[31:0]; end
            `OPC_SLL:   begin sh = int'(imm % 32); s = ua * (longint'(1) << sh); r = s[31:0]; end
            `OPC_SRL:   begin sh = int'(imm % 32); s = ua / (longint'(1) << sh); r = s[31:0]; end
            `OPC_SRA:   begin sh = int'(imm % 32); s = sa >>> sh; r = s[31:0]; end
            `OPC_SLLV:  begin sh = int'(a % 32); s = ub * (longint'(1) << sh); r = s[31:0]; end
            `OPC_SRLV:  begin sh = int'(a % 32); s = ub / (longint'(1) << sh); r = s[31:0]; end
            `OPC_SRAV:  begin sh = int'(a % 32); s = sb >>> sh; r = s[31:0]; end
            `OPC_MFHI, `OPC_MTHI, `OPC_MFLO, `OPC_MTLO: r = a;
            `OPC_NOP:   wr = 1'b0;
            default: begin wr = 1'b0; ex = 1'b0; end
        endcase
        return {r, 1'b0, wr, 1'b0, ex, ec, 1'b0};
    endfunction

    // scoreboard: compare every cycle, then book the transfers of the coming edge
    always @(negedge clk) begin
        logic exp_valid;
        if (rst) begin
            exp_q.delete();
            due_q.delete();
        end else begin
            exp_valid = (exp_q.size() > 0) && (due_q[0] <= edge_cnt);
            check("sb_out_valid", out_valid_o, exp_valid);
            check("sb_in_ready", in_ready_o, (exp_q.size() < 2) || out_ready_i);
            if (exp_valid) check("sb_out_data", {result_o, flags_o, tag_o}, exp_q[0]);
            if (flush_i) begin
                exp_q.delete();
                due_q.delete();
            end else begin
                if (exp_valid && out_valid_o && out_ready_i) begin
                    void'(exp_q.pop_front());
                    void'(due_q.pop_front());
                end
                if (in_valid_i && in_ready_o) begin
                    exp_q.push_back({model(opcode_i, data1_i, data2_i, immd_i), tag_i});
                    due_q.push_back(edge_cnt + 2);
                end
            end
        end
    end

    // driver: offer one op until accepted; returns 1ns after the accepting edge
    task automatic send(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [15:0] imm, input logic [7:0] tag);
        int  n;
        logic acc;
        opcode_i = op; data1_i = a; data2_i = b; immd_i = imm; tag_i = tag;
        in_valid_i = 1'b1;
        n = 0; acc = 1'b0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready_o;
            @(posedge clk);
            #1;
            if (!acc) out_ready_i = 1'b1;
            n++;
        end
        if (!acc) check("send_timeout", 0, 1);
    endtask

    task automatic set_in(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [7:0] tag);
        opcode_i = op; data1_i = a; data2_i = b; immd_i = 16'h0; tag_i = tag;
        in_valid_i = 1'b1;
    endtask

    initial begin
        logic [W-1:0] snap;
        int n;
        t_op  = '{`OPC_ADD, `OPC_ADDU, `OPC_SUB, `OPC_SUB, `OPC_SUBU, `OPC_AND, `OPC_OR, `OPC_XOR,
                  `OPC_NOR, `OPC_SLT, `OPC_SLTU, `OPC_ADDI, `OPC_ADDIU, `OPC_SLTI, `OPC_SLTIU, `OPC_ANDI,
                  `OPC_ORI, `OPC_XORI, `OPC_LUI, `OPC_SLL, `OPC_SRL, `OPC_SRA, `OPC_SLLV, `OPC_SRLV,
                  `OPC_SRAV, `OPC_MFHI, `OPC_MTLO, `OPC_NOP, 6'h3F, `OPC_MTHI, `OPC_MFLO, `OPC_ADD};
        t_d1  = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'h0, 32'h80000000, 32'h5, 32'hA5A5A5A5, 32'hA5A5A5A5,
                  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h1, 32'h1, 32'h10, 32'hFFFFFFFF, 32'h5, 32'h5,
                  32'hFFFFFFFF, 32'h0, 32'hFFFF0000, 32'h0, 32'h3, 32'h80000000, 32'h80000000, 32'h24,
                  32'h3F, 32'h24, 32'hDEADBEEF, 32'h12345678, 32'h11111111, 32'hFFFFFFFF, 32'hCAFEF00D,
                  32'h0BADF00D, 32'h7FFFFFFF};
        t_d2  = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h7, 32'h0FF00FF0, 32'h0FF00FF0, 32'h0FF00FF0,
                  32'h0FF00FF0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                  32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1, 32'h80000000, 32'h80000000, 32'h0, 32'h0,
                  32'h22222222, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h1};
        t_imm = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0,
                  16'h8000, 16'h0001, 16'hFFFF, 16'hFFFF, 16'h8001, 16'h8000, 16'hFFFF, 16'h1234,
                  16'h001F, 16'h0021, 16'h0004, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h3333, 16'hFFFF,
                  16'h0, 16'h0, 16'h0};

        // pin the model against hand-computed values
        check("model_add_ovf", model(`OPC_ADD, 32'h7FFFFFFF, 32'h1, 16'h0),
              {32'h80000000, TRAP ? 6'h16 : 6'h14});
        check("model_sub_borrow", model(`OPC_SUB, 32'h0, 32'h1, 16'h0),
              {32'hFFFFFFFF, TRAP ? 6'h14 : 6'h16});
        check("model_slt", model(`OPC_SLT, 32'h1, 32'hFFFFFFFF, 16'h0), {32'h0, 6'h14});
        check("model_sltu", model(`OPC_SLTU, 32'h1, 32'hFFFFFFFF, 16'h0), {32'h1, 6'h14});
        check("model_srav", model(`OPC_SRAV, 32'h24, 32'h80000000, 16'h0), {32'hF8000000, 6'h14});
        check("model_lui", model(`OPC_LUI, 32'h0, 32'h0, 16'h1234), {32'h12340000, 6'h14});
        check("model_addi_neg", model(`OPC_ADDI, 32'h10, 32'h0, 16'h8000), {32'hFFFF8010, 6'h14});
        check("model_sltiu", model(`OPC_SLTIU, 32'h5, 32'h0, 16'hFFFF), {32'h1, 6'h14});
        check("model_nop", model(`OPC_NOP, 32'h1, 32'h2, 16'h3), {32'h0, 6'h04});
        check("model_unlisted", model(6'h3F, 32'h1, 32'h2, 16'h3), {32'h0, 6'h00});

        // reset
        rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        opcode_i = '0; data1_i = '0; data2_i = '0; immd_i = '0; tag_i = '0;
        #1;
        check("rst_out_valid", out_valid_o, 0);
        check("rst_outputs", {result_o, flags_o, tag_o}, 0);
        check("rst_in_ready", in_ready_o, 1);
        @(posedge clk); #3 rst = 1'b0;
        @(posedge clk); #1;

        // ADD with overflow, two-cycle latency
        send(`OPC_ADD, 32'h7FFFFFFF, 32'h1, 16'h0, 8'h05);
        in_valid_i = 1'b0;
        @(negedge clk);
        check("add_latency_early", out_valid_o, 0);
        @(negedge clk);
        check("add_out_valid", out_valid_o, 1);
        check("add_result", result_o, 32'h80000000);
        check("add_tag", tag_o, 8'h05);
        check("add_flags", flags_o, TRAP ? 6'h16 : 6'h14);
        @(posedge clk); #1;

        // directed table, with occasional consumer stalls
        for (int i = 0; i < NV; i++) begin
            out_ready_i = (i % 4 != 3);
            send(t_op[i], t_d1[i], t_d2[i], t_imm[i], 8'(8'h10 + i));
        end
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
        check("table_drain", exp_q.size(), 0);
        @(posedge clk); #1;

        // back-pressure: three ops offered while the consumer stalls
        out_ready_i = 1'b0;
        set_in(`OPC_ADD, 32'h1, 32'h2, 8'hA1);
        @(negedge clk); check("bp_ready_0", in_ready_o, 1);
        @(posedge clk); #1;
        set_in(`OPC_XOR, 32'hF0F0F0F0, 32'hFFFF0000, 8'hA2);
        @(negedge clk); check("bp_ready_1", in_ready_o, 1);
        @(posedge clk); #1;
        set_in(`OPC_SUB, 32'h10, 32'h3, 8'hA3);
        snap = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_ready_full", in_ready_o, 0);
            check("bp_valid_held", out_valid_o, 1);
            if (k == 0) begin
                snap = {result_o, flags_o, tag_o};
                check("bp_head", snap, {32'h3, 6'h14, 8'hA1});
            end else begin
                check("bp_stable", {result_o, flags_o, tag_o}, snap);
            end
            @(posedge clk); #1;
        end
        out_ready_i = 1'b1;
        @(negedge clk);
        check("bp_ready_comb", in_ready_o, 1);
        check("bp_out_a", {out_valid_o, tag_o}, {1'b1, 8'hA1});
        @(posedge clk); #1 in_valid_i = 1'b0;
        @(negedge clk); check("bp_out_b", {out_valid_o, result_o, tag_o}, {1'b1, 32'h0F0FF0F0, 8'hA2});
        @(posedge clk); #1;
        @(negedge clk); check("bp_out_c", {out_valid_o, result_o, tag_o}, {1'b1, 32'hD, 8'hA3});
        @(posedge clk); #1;
        @(negedge clk); check("bp_empty", out_valid_o, 0);
        @(posedge clk); #1;

        // flush with both stages full and a new op offered
        out_ready_i = 1'b0;
        set_in(`OPC_OR, 32'h1, 32'h2, 8'hB1);
        @(posedge clk); #1;
        set_in(`OPC_AND, 32'h3, 32'h6, 8'hB2);
        @(posedge clk); #1;
        set_in(`OPC_ADDU, 32'h4, 32'h4, 8'hB3);
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0; in_valid_i = 1'b0;
        @(negedge clk);
        check("flush_out_valid", out_valid_o, 0);
        check("flush_in_ready", in_ready_o, 1);
        out_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); check("flush_no_output", out_valid_o, 0);
        end
        @(posedge clk); #1;

        // reset in the middle of traffic
        out_ready_i = 1'b0;
        send(`OPC_ORI, 32'h100, 32'h0, 16'h00FF, 8'hC1);
        send(`OPC_NOR, 32'h0, 32'h0, 16'h0, 8'hC2);
        in_valid_i = 1'b0;
        @(negedge clk); check("mid_full", out_valid_o, 1);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid_o, 0);
        check("mid_rst_outputs", {result_o, flags_o, tag_o}, 0);
        check("mid_rst_in_ready", in_ready_o, 1);
        @(posedge clk); #3 rst = 1'b0;
        @(negedge clk);
        check("post_rst_out_valid", out_valid_o, 0);
        check("post_rst_in_ready", in_ready_o, 1);
        @(posedge clk); #1;
        out_ready_i = 1'b1;
        send(`OPC_SLTI, 32'hFFFFFFF0, 32'h0, 16'hFFFF, 8'hC3);
        in_valid_i = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin @(negedge clk); n++; end
        check("final_drain", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/simple_alu_pipe.md
# simple_alu_pipe

Parametrised, pipelined successor to the single-cycle integer ALU in the EXEC stage. It executes the same simple-integer opcode set over a configurable datapath width, behind a two-stage valid/ready pipeline. Each result carries an issue tag so that writeback and the active list can match it. A flush input kills in-flight work on mispredict recovery.

## Interface
- DATA_W, 32: operand and result width; must be greater than IMM_W and a power of two.
- IMM_W, 16: immediate width.
- TAG_W, 8: width of the issue tag carried alongside each operation.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush_i  in  1  synchronous kill of all in-flight operations.
- in_valid_i  in  1  operation offered.
- in_ready_o  out  1  pipeline can accept this cycle.
- opcode_i  in  `SIZE_OPCODE_I  operation, using the codebase opcode macros.
- data1_i, data2_i  in  DATA_W  source operands.
- immd_i  in  IMM_W  immediate.
- tag_i  in  TAG_W  issue tag.
- out_valid_o  out  1  result available.
- out_ready_i  in  1  consumer accepts the result.
- result_o  out  DATA_W  result.
- flags_o  out  `EXECUTION_FLAGS  execution flags, laid out as follows:
  - bit4: destination write.
  - bit2: executed.
  - bit1: exception.
  - bit0: mispredict, always 0.
  - All other bits are 0.
- tag_o  out  TAG_W  tag of the result.

## Operation
- Stage S1 holds the registered operands, opcode and tag.
- S1 is decoded combinationally, and the computed result and flags are written into output stage S2.
- Sign extension: sext(imm) = immd_i sign-replicated to DATA_W bits. ANDI, ORI, XORI and SLTIU zero-extend the immediate.
- ADD, ADDI, ADDU, ADDIU, SUB and SUBU compute modulo 2^DATA_W.
- Carry for ADD, ADDI and SUB is the carry-out at bit DATA_W. For SUB this is the borrow.
- Shift amount is the low log2(DATA_W) bits of immd_i (SLL, SRL, SRA) or of data1_i (SLLV, SRLV, SRAV). The shifted operand for the V forms is data2_i.
- SRA and SRAV are arithmetic shifts.
- SLT and SLTI use a true signed compare. SLTU and SLTIU use an unsigned compare. The result is 1 or 0, zero-extended.
- LUI: the result is immd_i in the upper bits with zeros in the low DATA_W-IMM_W bits.
- MFHI, MTHI, MFLO and MTLO pass data1_i through.
- Flags:
  - All listed opcodes except NOP set bit4 = 1 and bit2 = 1.
  - NOP returns result 0 with flags bit2 = 1 only.
  - Unlisted opcodes return result 0 with flags 0, and still flow through the pipeline.
- Handshakes:
  - A transfer occurs on a cycle where valid and ready are both high.
  - in_ready_o = !S1.valid || (!S2.valid || out_ready_i).
  - S1 advances into S2 when S2 is empty or draining.
  - Throughput is 1 operation per cycle.
  - Once out_valid_o is asserted, result_o, flags_o and tag_o hold stable until out_ready_i is sampled high.
- Flush:
  - flush_i clears both valid bits at the next edge.
  - An input offered in the same cycle as flush_i is discarded.
  - flush_i has priority over every other update.
- Reset:
  - All valid bits clear.
  - result_o, flags_o and tag_o reset to 0.
  - out_valid_o resets to 0, and in_ready_o is 1 after reset.
  - Reset asserted mid-operation drops all in-flight operations immediately.

## Timing
- Latency: an operation accepted at edge N shows out_valid_o = 1 after edge N+1, i.e. 2 cycles.
- With S1 and S2 both full and out_ready_i = 0, in_ready_o is 0.
- Back-pressure: out_ready_i affects in_ready_o in the same cycle (combinational path). There are no other combinational in-to-out paths.
- Simultaneous drain and accept when full: S2 takes S1 and S1 takes the new input, with no bubble.

## Configuration
- SIMPLE_ALU_OVF_TRAP_EN defined:
  - Flags bit1 for ADD, ADDI and SUB is the signed two's-complement overflow.
  - result_o still carries the wrapped value.
- Macro undefined: flags bit1 for ADD, ADDI and SUB is the raw carry/borrow-out.
- The unsigned forms (ADDU, ADDIU, SUBU) keep bit1 = 0 in both builds.

## Test plan
- ADD, data1=0x7FFFFFFF, data2=0x00000001, tag=0x05, out_ready held 1:
  - After 2 cycles: result 0x80000000, tag 0x05.
  - bit1 = 1 with SIMPLE_ALU_OVF_TRAP_EN, bit1 = 0 without.
- SLT, data1=0x00000001, data2=0xFFFFFFFF: result 0. SLTU with the same operands: result 1.
- SRAV, data1=0x00000024, data2=0x80000000: shift is 4, result 0xF8000000. LUI with immd=0x1234: result 0x12340000.
- Back-pressure:
  - Stimulus: issue 3 ops on consecutive cycles while out_ready=0.
  - in_ready drops after 2 are accepted, and the held output stays stable.
  - On raising out_ready, results emerge in order, one per cycle.
- flush_i asserted with both stages full plus a new input offered: out_valid=0 the next cycle, and none of the three ops ever appears.
- reset asserted mid-stream: outputs are 0 asynchronously and in_ready=1 after release.
